fetch_unit: RTL and testbench

- Instruction-fetch stage of the 5-stage MIPS pipeline.
- Owns PC_F and issues word reads to instruction memory over a req/ready handshake.
- Fills the IF/ID register (instr_D, PC_D, PC8_D, valid_D).
- Consumes the next-PC redirect produced by the decode-stage next-PC calculator.
- Honours the one-instruction branch delay slot.

---
 rtl/fetch_unit_if.sv | 10 +
 rtl/fetch_unit.sv | 113 +++++++++++
 tb/tb_fetch_unit.sv | 222 ++++++++++++++++++++++
 3 files changed

// File: rtl/fetch_unit_if.sv
// Instruction-memory read port: request/address out, ready/data back.
interface fetch_unit_if;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic        imem_ready;
    logic [31:0] imem_rdata;

    modport master (output imem_req, output imem_addr, input imem_ready, input imem_rdata);
    modport slave  (input imem_req, input imem_addr, output imem_ready, output imem_rdata);
endinterface

// File: rtl/fetch_unit.sv
// MIPS instruction-fetch stage: owns PC_F, reads imem, fills IF/ID and
// applies decode-stage redirects after the branch delay slot.
module fetch_unit #(
    parameter logic [31:0] RESET_PC = 32'h0000_3000
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               stall_D,
    input  logic               redirect,
    input  logic [31:0]        NPC,
    fetch_unit_if.master       imem,
    output logic [31:0]        instr_D,
    output logic [31:0]        PC_D,
    output logic [31:0]        PC8_D,
    output logic               valid_D,
    output logic               fetch_busy
);
    typedef enum logic {FETCH, HOLD} state_t;

    state_t      state;
    logic [31:0] pc_f;
    logic [31:0] redirect_pc;
    logic        pend;
    logic        req;
    logic [31:0] skid_instr;
    logic [31:0] skid_pc;

    logic        accept;
    logic        done;
    logic        redirect_ok;
    logic [31:0] npc_aligned;

    assign accept      = !stall_D || !valid_D;
    assign done        = req && imem.imem_ready;
    assign redirect_ok = redirect && valid_D && !stall_D;
    assign npc_aligned = NPC & 32'hFFFF_FFFC;

    assign imem.imem_req  = req;
    assign imem.imem_addr = pc_f;
    assign fetch_busy     = req && !imem.imem_ready;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state       <= FETCH;
            pc_f        <= RESET_PC;
            redirect_pc <= 32'd0;
            pend        <= 1'b0;
            req         <= 1'b0;
            skid_instr  <= 32'd0;
            skid_pc     <= 32'd0;
            instr_D     <= 32'd0;
            PC_D        <= 32'd0;
            PC8_D       <= 32'd0;
            valid_D     <= 1'b0;
        end else begin
            case (state)
                FETCH: begin
                    req <= 1'b1;
                    if (done && accept) begin
                        instr_D <= imem.imem_rdata;
                        PC_D    <= pc_f;
                        PC8_D   <= pc_f + 32'd8;
                        valid_D <= 1'b1;
                        if (redirect_ok) begin
                            pc_f <= npc_aligned;
                        end else if (pend) begin
                            pc_f <= redirect_pc;
                            pend <= 1'b0;
                        end else begin
                            pc_f <= pc_f + 32'd4;
                        end
                    end else if (done) begin
                        // Decode is stalled: park the word so the bus can go idle.
                        skid_instr <= imem.imem_rdata;
                        skid_pc    <= pc_f;
                        if (pend) begin
                            pc_f <= redirect_pc;
                            pend <= 1'b0;
                        end else begin
                            pc_f <= pc_f + 32'd4;
                        end
                        req   <= 1'b0;
                        state <= HOLD;
                    end else begin
                        if (accept) begin
                            valid_D <= 1'b0;
                        end
                        // The word still in flight is the delay slot; apply target afterwards.
                        if (redirect_ok) begin
                            redirect_pc <= npc_aligned;
                            pend        <= 1'b1;
                        end
                    end
                end
                HOLD: begin
                    req <= 1'b0;
                    if (accept) begin
                        instr_D <= skid_instr;
                        PC_D    <= skid_pc;
                        PC8_D   <= skid_pc + 32'd8;
                        valid_D <= 1'b1;
                        req     <= 1'b1;
                        state   <= FETCH;
                        if (redirect_ok) begin
                            pc_f <= npc_aligned;
                        end
                    end
                end
                default: state <= FETCH;
            endcase
        end
    end
endmodule

// File: tb/tb_fetch_unit.sv
// Bench for fetch_unit: directed scenarios plus an architectural program-order
// model that checks every instruction entering IF/ID.
module tb_fetch_unit;
    logic        clk = 1'b0;
    logic        rst_n;
    logic        stall_D;
    logic        redirect;
    logic [31:0] NPC;
    logic [31:0] instr_D;
    logic [31:0] PC_D;
    logic [31:0] PC8_D;
    logic        valid_D;
    logic        fetch_busy;
    logic        ready_v;
    logic [31:0] bad_addr;

    int n_checks = 0;
    int n_fail   = 0;

    always #5 clk = ~clk;

    function automatic logic [31:0] mem_word(input logic [31:0] a);
        return a ^ 32'h8C00_0000;
    endfunction

    fetch_unit_if bus ();
    assign bus.imem_ready = ready_v;
    assign bus.imem_rdata = mem_word(bus.imem_addr);

    fetch_unit #(.RESET_PC(32'h0000_3000)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .stall_D    (stall_D),
        .redirect   (redirect),
        .NPC        (NPC),
        .imem       (bus),
        .instr_D    (instr_D),
        .PC_D       (PC_D),
        .PC8_D      (PC8_D),
        .valid_D    (valid_D),
        .fetch_busy (fetch_busy)
    );

    task automatic chk(input string nm, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", nm, got, exp);
        end
    endtask

    task automatic step();
        @(negedge clk);
    endtask

    // Architectural model: the next PC that must enter IF/ID, plus one
    // branch target that takes effect after the delay slot has entered.
    logic [31:0] seq_next;
    logic        tgt_pending;
    logic [31:0] tgt;

    initial begin
        logic        s_rst, s_valid, s_stall, s_redirect, s_req, s_ready;
        logic [31:0] s_npc, s_addr, s_instr, s_pc, s_pc8;
        seq_next    = 32'h0000_3000;
        tgt_pending = 1'b0;
        tgt         = 32'd0;
        forever begin
            @(posedge clk);
            s_rst = rst_n; s_valid = valid_D; s_stall = stall_D;
            s_redirect = redirect; s_npc = NPC;
            s_req = bus.imem_req; s_ready = bus.imem_ready; s_addr = bus.imem_addr;
            s_instr = instr_D; s_pc = PC_D; s_pc8 = PC8_D;
            #1;
            if (!rst_n) begin
                chk("m_rst_valid", 32'(valid_D), 32'd0);
                chk("m_rst_req", 32'(bus.imem_req), 32'd0);
                seq_next    = 32'h0000_3000;
                tgt_pending = 1'b0;
            end else if (s_rst) begin
                if (s_req && s_ready)
                    chk("m_forbidden_fetch", 32'(s_addr == bad_addr), 32'd0);
                if (s_valid && !s_stall && s_redirect) begin
                    tgt_pending = 1'b1;
                    tgt         = s_npc & 32'hFFFF_FFFC;
                end
                if (s_valid && s_stall) begin
                    chk("m_hold_valid", 32'(valid_D), 32'd1);
                    chk("m_hold_pc", PC_D, s_pc);
                    chk("m_hold_instr", instr_D, s_instr);
                    chk("m_hold_pc8", PC8_D, s_pc8);
                end else if (valid_D) begin
                    $display("IFID pc=%h instr=%h pc8=%h", PC_D, instr_D, PC8_D);
                    chk("m_order_pc", PC_D, seq_next);
                    chk("m_instr", instr_D, mem_word(seq_next));
                    chk("m_pc8", PC8_D, seq_next + 32'd8);
                    if (tgt_pending) begin
                        seq_next    = tgt;
                        tgt_pending = 1'b0;
                    end else begin
                        seq_next = seq_next + 32'd4;
                    end
                end
                if (s_req && !s_ready) begin
                    chk("m_wait_req", 32'(bus.imem_req), 32'd1);
                    chk("m_wait_addr", bus.imem_addr, s_addr);
                end
                if (bus.imem_req)
                    chk("m_addr_align", 32'(bus.imem_addr[1:0]), 32'd0);
            end
        end
    end

    initial begin
        rst_n = 1'b0; stall_D = 1'b0; redirect = 1'b0; NPC = 32'd0;
        ready_v = 1'b1; bad_addr = 32'h0000_0001;
        repeat (2) step();
        chk("rst_valid", 32'(valid_D), 32'd0);
        chk("rst_req", 32'(bus.imem_req), 32'd0);
        chk("rst_pc_d", PC_D, 32'd0);
        chk("rst_instr", instr_D, 32'd0);
        chk("rst_pc8", PC8_D, 32'd0);

        // Zero-wait sequential run
        rst_n = 1'b1;
        step();
        chk("seq_addr0", bus.imem_addr, 32'h0000_3000);
        chk("seq_req0", 32'(bus.imem_req), 32'd1);
        chk("seq_valid0", 32'(valid_D), 32'd0);
        step();
        chk("seq_addr1", bus.imem_addr, 32'h0000_3004);
        chk("seq_pc_d1", PC_D, 32'h0000_3000);
        chk("seq_pc8_1", PC8_D, 32'h0000_3008);
        chk("seq_valid1", 32'(valid_D), 32'd1);
        chk("seq_instr1", instr_D, 32'h8C00_3000);
        step();
        chk("seq_addr2", bus.imem_addr, 32'h0000_3008);
        chk("seq_pc_d2", PC_D, 32'h0000_3004);
        step();
        chk("seq_pc_d3", PC_D, 32'h0000_3008);
        chk("seq_addr3", bus.imem_addr, 32'h0000_300C);

        // Taken branch at 3008, delay slot 300C, target 3040
        redirect = 1'b1; NPC = 32'h0000_3040; bad_addr = 32'h0000_3010;
        step();
        redirect = 1'b0;
        chk("br_delay_slot", PC_D, 32'h0000_300C);
        chk("br_addr_tgt", bus.imem_addr, 32'h0000_3040);
        step();
        chk("br_tgt_pc_d", PC_D, 32'h0000_3040);
        chk("br_addr_next", bus.imem_addr, 32'h0000_3044);

        // Redirect during three wait-state cycles
        bad_addr = 32'h0000_0001;
        ready_v = 1'b0; redirect = 1'b1; NPC = 32'h0000_3100;
        step();
        redirect = 1'b0;
        chk("ws_bubble", 32'(valid_D), 32'd0);
        chk("ws_addr", bus.imem_addr, 32'h0000_3044);
        chk("ws_busy", 32'(fetch_busy), 32'd1);
        step(); step();
        chk("ws_bubble2", 32'(valid_D), 32'd0);
        chk("ws_addr2", bus.imem_addr, 32'h0000_3044);
        ready_v = 1'b1;
        step();
        chk("ws_slot_pc", PC_D, 32'h0000_3044);
        chk("ws_slot_valid", 32'(valid_D), 32'd1);
        chk("ws_addr_tgt", bus.imem_addr, 32'h0000_3100);
        step();
        chk("ws_tgt_pc_d", PC_D, 32'h0000_3100);

        // Stall for four cycles while the fetch of 3104 completes
        stall_D = 1'b1;
        step();
        chk("st_req_low", 32'(bus.imem_req), 32'd0);
        chk("st_pc_d", PC_D, 32'h0000_3100);
        step(); step(); step();
        chk("st_pc_d_late", PC_D, 32'h0000_3100);
        chk("st_busy", 32'(fetch_busy), 32'd0);
        stall_D = 1'b0;
        step();
        chk("st_rel_pc_d", PC_D, 32'h0000_3104);
        chk("st_rel_addr", bus.imem_addr, 32'h0000_3108);
        chk("st_rel_req", 32'(bus.imem_req), 32'd1);

        // Asynchronous reset in the middle of an outstanding request
        ready_v = 1'b0; stall_D = 1'b1;
        step();
        chk("ar_pre_valid", 32'(valid_D), 32'd1);
        chk("ar_pre_addr", bus.imem_addr, 32'h0000_3108);
        #2 rst_n = 1'b0;
        #1;
        chk("ar_valid", 32'(valid_D), 32'd0);
        chk("ar_req", 32'(bus.imem_req), 32'd0);
        chk("ar_pc_d", PC_D, 32'd0);
        step(); step();
        rst_n = 1'b1; stall_D = 1'b0; ready_v = 1'b1;
        step();
        chk("ar_first_addr", bus.imem_addr, 32'h0000_3000);
        chk("ar_first_req", 32'(bus.imem_req), 32'd1);
        step();
        chk("ar_first_pc_d", PC_D, 32'h0000_3000);

        // jr to an unaligned top-of-memory target, then wrap
        redirect = 1'b1; NPC = 32'hFFFF_FFFE;
        step();
        redirect = 1'b0;
        chk("wr_slot_pc", PC_D, 32'h0000_3004);
        chk("wr_addr", bus.imem_addr, 32'hFFFF_FFFC);
        step();
        chk("wr_pc_d", PC_D, 32'hFFFF_FFFC);
        chk("wr_pc8", PC8_D, 32'h0000_0004);
        chk("wr_addr_wrap", bus.imem_addr, 32'h0000_0000);
        step();
        chk("wr_pc_d0", PC_D, 32'h0000_0000);
        chk("wr_pc8_0", PC8_D, 32'h0000_0008);
        step();

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
